// File: rtl/alu_prefix_pipe_if.sv
// alu_prefix_pipe_if: operand/result bundle between decode/execute and the ALU pipeline.
interface alu_prefix_pipe_if #(parameter int W = 64);
   logic         in_valid;
   logic [1:0]   alufun;
   logic [W-1:0] aluA;
   logic [W-1:0] aluB;
   logic         set_cc;
   logic         stall;
   logic         flush;
   logic         out_valid;
   logic [W-1:0] valE;
   logic         zf;
   logic         sf;
   logic         of;
   logic [2:0]   cc;
   modport master (output in_valid, alufun, aluA, aluB, set_cc, stall, flush,
                   input out_valid, valE, zf, sf, of, cc);
   modport slave (input in_valid, alufun, aluA, aluB, set_cc, stall, flush,
                  output out_valid, valE, zf, sf, of, cc);
endinterface

// File: rtl/alu_prefix_pipe.sv
// alu_prefix_pipe: 3-stage Y86 ALU on a Kogge-Stone adder cut after CUT prefix levels.
// Requires 1 <= CUT < log2(W).
module alu_prefix_pipe #(
   parameter int W   = 64,
   parameter int CUT = 3
) (
   input logic clk,
   input logic rst_n,
   alu_prefix_pipe_if.slave bus
);
   localparam int L = $clog2(W);
   logic         sub;
   logic [W-1:0] a_x;
   assign sub = bus.alufun == 2'd1;
   assign a_x = sub ? ~bus.aluA : bus.aluA;
   logic         v1, s1_cin, s1_scc, s1_as, s1_bs;
   logic [1:0]   s1_fn;
   logic [W-1:0] s1_p, s1_g, s1_lr;
   logic         v2, s2_cin, s2_scc, s2_as, s2_bs;
   logic [1:0]   s2_fn;
   logic [W-1:0] s2_p, s2_lr, s2_gg, s2_pp;
   logic         v3, s3_z, s3_s, s3_o, s3_scc;
   logic [W-1:0] s3_val;
   logic [2:0]   cc_q;
   logic [W-1:0] gi [L];
   logic [W-1:0] pi [L];
   logic [W-1:0] go [L];
   logic [W-1:0] po [L];
   // Each level is a row of green nodes at distance 2^k; ~(~p << d) feeds ones into the pass-through low bits.
   for (genvar k = 0; k < L; k++) begin : g_lvl
      if (k == 0) begin : g_src1
         assign gi[k] = s1_g;
         assign pi[k] = s1_p;
      end else if (k == CUT) begin : g_src2
         assign gi[k] = s2_gg;
         assign pi[k] = s2_pp;
      end else begin : g_chain
         assign gi[k] = go[k-1];
         assign pi[k] = po[k-1];
      end
      assign go[k] = gi[k] | (pi[k] & (gi[k] << (1 << k)));
      assign po[k] = pi[k] & ~(~pi[k] << (1 << k));
   end
   logic [W-1:0] c, sum, res;
   logic         of_n;
   assign c    = {go[L-1][W-2:0] | (po[L-1][W-2:0] & {(W-1){s2_cin}}), s2_cin};
   assign sum  = s2_p ^ c;
   assign res  = s2_fn[1] ? s2_lr : sum;
   assign of_n = (s2_fn == 2'd0) ? (s2_as == s2_bs) & (sum[W-1] != s2_bs) :
                 (s2_fn == 2'd1) ? (s2_as != s2_bs) & (sum[W-1] != s2_bs) : 1'b0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         s1_cin <= 1'b0;
         s1_scc <= 1'b0;
         s1_as  <= 1'b0;
         s1_bs  <= 1'b0;
         s1_fn  <= '0;
         s1_p   <= '0;
         s1_g   <= '0;
         s1_lr  <= '0;
         v2     <= 1'b0;
         s2_cin <= 1'b0;
         s2_scc <= 1'b0;
         s2_as  <= 1'b0;
         s2_bs  <= 1'b0;
         s2_fn  <= '0;
         s2_p   <= '0;
         s2_lr  <= '0;
         s2_gg  <= '0;
         s2_pp  <= '0;
         v3     <= 1'b0;
         s3_z   <= 1'b0;
         s3_s   <= 1'b0;
         s3_o   <= 1'b0;
         s3_scc <= 1'b0;
         s3_val <= '0;
         cc_q   <= 3'b100;
      end else if (!bus.stall) begin
         v1     <= bus.in_valid & ~bus.flush;
         s1_cin <= sub;
         s1_scc <= bus.set_cc;
         s1_as  <= bus.aluA[W-1];
         s1_bs  <= bus.aluB[W-1];
         s1_fn  <= bus.alufun;
         s1_p   <= bus.aluB ^ a_x;
         s1_g   <= bus.aluB & a_x;
         s1_lr  <= bus.alufun[0] ? bus.aluB ^ bus.aluA : bus.aluB & bus.aluA;
         v2     <= v1 & ~bus.flush;
         s2_cin <= s1_cin;
         s2_scc <= s1_scc;
         s2_as  <= s1_as;
         s2_bs  <= s1_bs;
         s2_fn  <= s1_fn;
         s2_p   <= s1_p;
         s2_lr  <= s1_lr;
         s2_gg  <= go[CUT-1];
         s2_pp  <= po[CUT-1];
         v3     <= v2 & ~bus.flush;
         s3_z   <= res == '0;
         s3_s   <= res[W-1];
         s3_o   <= of_n;
         s3_scc <= s2_scc;
         s3_val <= res;
         if (!bus.flush && v3 && s3_scc) cc_q <= {s3_z, s3_s, s3_o};
      end
   end
   assign bus.out_valid = v3;
   assign bus.valE      = s3_val;
   assign bus.zf        = s3_z;
   assign bus.sf        = s3_s;
   assign bus.of        = s3_o;
   assign bus.cc        = cc_q;
endmodule

// File: tb/tb_alu_prefix_pipe.sv
// tb_alu_prefix_pipe: directed and randomized checks against a 3-slot behavioural model.
module tb_alu_prefix_pipe;
   typedef struct packed {
      logic        v;
      logic [63:0] val;
      logic        z, s, o, scc;
   } op_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int nvec = 0;
   int nerr = 0;
   op_t pipe [3];
   logic [2:0] mcc;
   alu_prefix_pipe_if #(.W(64)) bus ();
   alu_prefix_pipe #(.W(64), .CUT(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   logic [1:0]  d_fn [5] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3};
   logic [63:0] d_a  [5] = '{64'd5, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0123_4567_89AB_CDEF};
   logic [63:0] d_b  [5] = '{64'd7, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF};
   logic [63:0] d_v  [5] = '{64'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0};
   logic [2:0]  d_f  [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b100};
   // Overflow from a 65-bit signed computation rather than sign-bit rules.
   function automatic op_t ref_op(input logic v, input logic [1:0] fn, input logic [63:0] a, b,
                                  input logic scc);
      op_t r;
      logic [64:0] wide;
      r.v   = v;
      r.scc = scc;
      wide  = (fn == 2'd1) ? {b[63], b} - {a[63], a} : {b[63], b} + {a[63], a};
      case (fn)
         2'd0, 2'd1: r.val = wide[63:0];
         2'd2:       r.val = b & a;
         default:    r.val = b ^ a;
      endcase
      r.z = r.val == 64'd0;
      r.s = r.val[63];
      r.o = (fn[1] == 1'b0) && (wide[64] != wide[63]);
      return r;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '0;
      mcc = 3'b100;
   endtask
   task automatic step(input logic iv, input logic [1:0] fn, input logic [63:0] a, b,
                       input logic scc, st, fl);
      bus.in_valid = iv;
      bus.alufun   = fn;
      bus.aluA     = a;
      bus.aluB     = b;
      bus.set_cc   = scc;
      bus.stall    = st;
      bus.flush    = fl;
      @(posedge clk);
      if (!st) begin
         if (!fl && pipe[2].v && pipe[2].scc) mcc = {pipe[2].z, pipe[2].s, pipe[2].o};
         if (fl) begin
            for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
         end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = ref_op(iv, fn, a, b, scc);
         end
      end
      #1;
   endtask
   task automatic bubble();
      step(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
   endtask
   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.alufun   = 2'd0;
      bus.aluA     = '0;
      bus.aluB     = '0;
      bus.set_cc   = 1'b0;
      bus.stall    = 1'b0;
      bus.flush    = 1'b0;
      model_reset();
      #12;
      nvec++;
      if ({bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of} !== '0) begin
         nerr++;
         $display("FAIL reset_outputs got v=%b valE=%h f=%b%b%b want all zero",
                  bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of);
      end
      nvec++;
      if (bus.cc !== 3'b100) begin
         nerr++;
         $display("FAIL reset_cc got %b want 100", bus.cc);
      end
      #10 rst_n = 1'b1;
   endtask
   task automatic test_directed();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, d_fn[i], d_a[i], d_b[i], 1'b1, 1'b0, 1'b0);
         bubble();
         bubble();
         nvec++;
         if ({bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of} !== {1'b1, d_v[i], d_f[i]}) begin
            nerr++;
            $display("FAIL directed[%0d] got v=%b valE=%h zso=%b%b%b want v=1 valE=%h zso=%b",
                     i, bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of, d_v[i], d_f[i]);
         end
         bubble();
         nvec++;
         if (bus.cc !== d_f[i]) begin
            nerr++;
            $display("FAIL directed_cc[%0d] got %b want %b", i, bus.cc, d_f[i]);
         end
      end
   endtask
   task automatic test_back_to_back();
      op_t exp [4];
      logic [63:0] a, b, got[$];
      logic [1:0] fn;
      for (int i = 0; i < 4; i++) begin
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         fn = 2'($urandom_range(0, 3));
         exp[i] = ref_op(1'b1, fn, a, b, 1'b1);
         if (i == 3) begin
            for (int s = 0; s < 2; s++) begin
               step(1'b1, 2'd0, {$urandom, $urandom}, 64'd1, 1'b1, 1'b1, 1'b0);
               nvec++;
               if (bus.out_valid !== 1'b1 || bus.valE !== exp[0].val) begin
                  nerr++;
                  $display("FAIL b2b_stall_hold got v=%b valE=%h want v=1 valE=%h",
                           bus.out_valid, bus.valE, exp[0].val);
               end
            end
         end
         step(1'b1, fn, a, b, 1'b1, 1'b0, 1'b0);
         if (bus.out_valid) got.push_back(bus.valE);
      end
      for (int i = 0; i < 4; i++) begin
         bubble();
         if (bus.out_valid) got.push_back(bus.valE);
      end
      nvec++;
      if (got.size() != 4) begin
         nerr++;
         $display("FAIL b2b_count got %0d want 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         nvec++;
         if (got[i] !== exp[i].val) begin
            nerr++;
            $display("FAIL b2b_order[%0d] got %h want %h", i, got[i], exp[i].val);
         end
      end
      nvec++;
      if (bus.cc !== {exp[3].z, exp[3].s, exp[3].o}) begin
         nerr++;
         $display("FAIL b2b_cc got %b want %b", bus.cc, {exp[3].z, exp[3].s, exp[3].o});
      end
   endtask
   task automatic test_flush();
      #3 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      step(1'b1, 2'd0, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0);
      step(1'b1, 2'd0, 64'd1, 64'd2, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         bubble();
         nvec++;
         if (bus.out_valid !== 1'b0 || bus.cc !== 3'b100) begin
            nerr++;
            $display("FAIL flush[%0d] got v=%b cc=%b want v=0 cc=100", i, bus.out_valid, bus.cc);
         end
      end
   endtask
   task automatic test_async_reset();
      for (int i = 0; i < 3; i++)
         step(1'b1, 2'd0, 64'(i + 1), 64'd100, 1'b1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if ({bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of, bus.cc} !== {67'd0, 3'b100}) begin
         nerr++;
         $display("FAIL async_reset got v=%b valE=%h zso=%b%b%b cc=%b want 0/0/000/100",
                  bus.out_valid, bus.valE, bus.zf, bus.sf, bus.of, bus.cc);
      end
      #3 rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         bubble();
         nvec++;
         if (bus.out_valid !== 1'b0 || bus.cc !== 3'b100) begin
            nerr++;
            $display("FAIL async_release[%0d] got v=%b cc=%b want v=0 cc=100", i, bus.out_valid, bus.cc);
         end
      end
      step(1'b1, 2'd1, 64'd3, 64'd10, 1'b0, 1'b0, 1'b0);
      bubble();
      bubble();
      nvec++;
      if (bus.out_valid !== 1'b1 || bus.valE !== 64'd7) begin
         nerr++;
         $display("FAIL async_first got v=%b valE=%h want v=1 valE=7", bus.out_valid, bus.valE);
      end
   endtask
   task automatic test_random();
      logic [63:0] ops [4];
      for (int n = 0; n < 400; n++) begin
         ops = '{{$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0};
         step(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? ops[$urandom_range(1, 3)] : {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? ops[$urandom_range(1, 3)] : {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0));
         nvec++;
         if (bus.out_valid !== pipe[2].v) begin
            nerr++;
            $display("FAIL rand_valid[%0d] got %b want %b", n, bus.out_valid, pipe[2].v);
         end
         if (pipe[2].v) begin
            nvec++;
            if ({bus.valE, bus.zf, bus.sf, bus.of} !== {pipe[2].val, pipe[2].z, pipe[2].s, pipe[2].o}) begin
               nerr++;
               $display("FAIL rand_result[%0d] got %h/%b%b%b want %h/%b%b%b", n, bus.valE, bus.zf,
                        bus.sf, bus.of, pipe[2].val, pipe[2].z, pipe[2].s, pipe[2].o);
            end
         end
         nvec++;
         if (bus.cc !== mcc) begin
            nerr++;
            $display("FAIL rand_cc[%0d] got %b want %b", n, bus.cc, mcc);
         end
      end
   endtask
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/alu_prefix_pipe.md
Name: alu_prefix_pipe

Overview:
- Pipelined 64-bit integer ALU for the Y86 execute stage, built on the Kogge-Stone parallel-prefix network.
- It instantiates the existing green prefix nodes and adds registered slices at two cut points.
- It consumes operands and the ALU function from the decode/execute boundary.
- It produces valE, the condition flags and a committed condition-code register for the memory/writeback stages.

Parameters:
- W, 64, operand/result width; power of two, minimum 8.
- CUT, 3, number of prefix levels completed in stage 2; the remaining log2(W)-CUT levels run in stage 3.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set present this cycle.
- alufun  input  2  0=ADD, 1=SUB, 2=AND, 3=XOR (Y86 encoding).
- aluA  input  W  operand A (valA/valC).
- aluB  input  W  operand B (valB).
- set_cc  input  1  update the CC register when this operation retires.
- stall  input  1  freeze every pipeline register.
- flush  input  1  kill all in-flight operations (bubble insertion).
- out_valid  output  1  valE is valid this cycle.
- valE  output  W  result.
- zf, sf, of  output  1 each  flags of the retiring operation (combinational from stage-3 register).
- cc  output  3  committed {ZF,SF,OF} register.

Behaviour:
- Operation semantics:
  - ADD: valE = aluB + aluA.
  - SUB: valE = aluB - aluA, computed as aluB + ~aluA + 1.
  - AND: valE = aluB & aluA.
  - XOR: valE = aluB ^ aluA.
  - All results are modulo 2^W; carry-out is discarded.
- Stage 1 (S1 register):
  - Form B and A' (A' = ~aluA for SUB, else aluA).
  - Bitwise p = B^A', g = B&A'; cin = 1 for SUB.
  - Latch p, g, cin, alufun, set_cc, original operand sign bits, AND/XOR result, valid.
- Stage 2 (S2 register): prefix levels 0..CUT-1, each node being a standard green node (g = g_hi | p_hi&g_lo; p = p_hi&p_lo). Latch the partial (G,P) vectors.
- Stage 3 (S3 register):
  - Finish the remaining levels; carry c[i] = G[i-1:0] | P[i-1:0]&cin.
  - sum = p ^ c.
  - Select the result by alufun and compute flags; latch.
- Latency and throughput: exactly 3 cycles from an accepted input to out_valid with no stall; one operation per cycle.
- Flags:
  - zf = (valE == 0); sf = valE[W-1].
  - of(ADD) = (A[W-1]==B[W-1]) & (valE[W-1]!=B[W-1]).
  - of(SUB) = (A[W-1]!=B[W-1]) & (valE[W-1]!=B[W-1]).
  - of = 0 for AND/XOR.
- CC commit: cc <= {zf,sf,of} at the clock edge when out_valid & set_cc & !stall; otherwise cc holds.
- stall=1: S1–S3 and cc hold; in_valid is ignored (the upstream stage also holds); outputs stay stable.
- flush=1 and not stall: valid bits of S1–S3 clear at the next edge. The input presented this cycle is also dropped. Data fields may retain stale values. cc does not update for the operation retiring on that edge.
- stall and flush together: stall wins; nothing changes.
- Reset (any time, asynchronous):
  - All valid bits = 0, out_valid = 0, valE = 0, zf/sf/of = 0.
  - cc = 3'b100 (Y86 reset state ZF=1).
  - In-flight operations are lost; the first valid input after release appears 3 cycles later.
- Bubble (in_valid=0) propagates as out_valid=0 and never touches cc.

Test Plan:
- Reset then ADD aluA=5, aluB=7, set_cc=1 → 3 cycles later out_valid=1, valE=12, zf=0 sf=0 of=0; cc=3'b000 the following cycle.
- SUB aluA=1, aluB=0x8000_0000_0000_0000 → valE=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0; ADD aluA=aluB=0x7FFF_FFFF_FFFF_FFFF → valE=0xFFFF_FFFF_FFFF_FFFE, of=1, sf=1.
- Full carry chain: ADD aluA=1, aluB=0xFFFF_FFFF_FFFF_FFFF → valE=0, zf=1; XOR with equal operands → valE=0, zf=1, of=0.
- Back-to-back issue of 4 ops with stall asserted 2 cycles mid-stream → results emerge in order, each exactly once, with valE held constant during the stall.
- flush on the cycle after issuing ADD(set_cc=1) → no out_valid for that op, cc unchanged (still 3'b100 after reset).
- Assert rst_n=0 asynchronously while 3 ops are in flight → outputs clear immediately without a clock edge, cc=3'b100, no stale out_valid after release.
